// File: rtl/uart_tx_responder_pkg.sv
// Shared constants for the UART transmit peripheral.
// Holds the register offsets relative to BASE, the STATUS bit positions,
// the serializer state encoding and a helper that packs the STATUS word.
package uart_tx_responder_pkg;

  // Register offsets from the peripheral base address.
  localparam logic [31:0] OFS_TXDATA = 32'd0;
  localparam logic [31:0] OFS_STATUS = 32'd4;
  localparam logic [31:0] OFS_CTRL   = 32'd8;

  // STATUS bit positions.
  localparam int unsigned STAT_BUSY     = 0;
  localparam int unsigned STAT_FULL     = 1;
  localparam int unsigned STAT_EMPTY    = 2;
  localparam int unsigned STAT_OVERFLOW = 3;
  localparam int unsigned STAT_TX_DONE  = 4;

  // Serializer state encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic tx_done;
    logic overflow;
    logic empty;
    logic full;
    logic busy;
  } status_t;

  function automatic logic [31:0] pack_status(input status_t s);
    logic [31:0] w;
    w                = '0;
    w[STAT_BUSY]     = s.busy;
    w[STAT_FULL]     = s.full;
    w[STAT_EMPTY]    = s.empty;
    w[STAT_OVERFLOW] = s.overflow;
    w[STAT_TX_DONE]  = s.tx_done;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO used as the transmit byte queue.
// Ports:
//   clk, reset  - clock and synchronous active-high reset (empties the FIFO)
//   push, din   - write din when push is high and the FIFO is not full
//   pop, dout   - dout shows the head entry; pop advances past it when not empty
//   full, empty - occupancy flags derived from the entry count
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // A simultaneous push and pop leaves the count unchanged.
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_responder.sv
// Memory-mapped UART transmitter: a bus-writable byte queue feeding an
// 8N1 serializer, with a STATUS register and a transmit-done interrupt.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   rd, wr     - single-cycle read / write strobes; an access is taken in any
//                cycle its strobe is high at a decoded address, there is no
//                wait state and no handshake back to the master
//   addr       - byte address; only BASE, BASE+4, BASE+8 decode
//   wdata      - write data (TXDATA uses [7:0], CTRL uses [0])
//   rdata      - combinational read data, zero unless a decoded read
//   TX         - serial output, idle high
//   irqout     - level interrupt, tx_done masked by irq_en
module uart_tx_responder
  import uart_tx_responder_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE         = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        TX,
  output logic        irqout
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  // Address decode
  logic sel_txdata, sel_status, sel_ctrl;
  logic wr_txdata, wr_ctrl, rd_status, rd_ctrl;

  assign sel_txdata = (addr == BASE + OFS_TXDATA);
  assign sel_status = (addr == BASE + OFS_STATUS);
  assign sel_ctrl   = (addr == BASE + OFS_CTRL);
  assign wr_txdata  = wr && sel_txdata;
  assign wr_ctrl    = wr && sel_ctrl;
  assign rd_status  = rd && sel_status;
  assign rd_ctrl    = rd && sel_ctrl;

  // Upper write-data bits carry no meaning for any register.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  // Transmit queue
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  tx_state_e  state_q;
  logic [15:0] baud_q;
  logic [2:0] bit_idx_q;
  logic [7:0] shift_q;
  logic       tx_q;

  // Full is judged on the count before the edge, so a pop in the same
  // cycle does not rescue a write into a full queue.
  assign fifo_push = wr_txdata && !fifo_full;
  assign fifo_pop  = (state_q == ST_IDLE) && !fifo_empty;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Serializer
  logic baud_wrap, frame_done;
  assign baud_wrap  = (baud_q == BAUD_LAST);
  assign frame_done = (state_q == ST_STOP) && baud_wrap;

  // The IDLE cycle that pops the next byte is why back-to-back frames are
  // 10*CLKS_PER_BIT+1 cycles apart.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_dout;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (baud_wrap) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= ST_DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_wrap) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              tx_q      <= 1'b1;
              state_q   <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            state_q <= ST_IDLE;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          baud_q  <= '0;
          tx_q    <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign TX = tx_q;

  // Status and control registers
  logic tx_done_q, tx_done_d;
  logic overflow_q, overflow_d;
  logic irq_en_q, irq_en_d;

  // A STATUS read clears the sticky bits, but a set event in the same
  // cycle takes priority so no event is lost.
  always_comb begin
    tx_done_d  = tx_done_q;
    overflow_d = overflow_q;
    irq_en_d   = irq_en_q;
    if (rd_status) begin
      tx_done_d  = 1'b0;
      overflow_d = 1'b0;
    end
    if (frame_done) tx_done_d = 1'b1;
    if (wr_txdata && fifo_full) overflow_d = 1'b1;
    if (wr_ctrl) irq_en_d = wdata[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_done_q  <= 1'b0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      tx_done_q  <= tx_done_d;
      overflow_q <= overflow_d;
      irq_en_q   <= irq_en_d;
    end
  end

  assign irqout = tx_done_q & irq_en_q;

  status_t status;
  assign status = '{tx_done:  tx_done_q,
                    overflow: overflow_q,
                    empty:    fifo_empty,
                    full:     fifo_full,
                    busy:     (state_q != ST_IDLE)};

  always_comb begin
    rdata = '0;
    if (rd_status) begin
      rdata = pack_status(status);
    end else if (rd_ctrl) begin
      rdata = {31'b0, irq_en_q};
    end
  end

endmodule

// File: tb/tb_uart_tx_responder.sv
module tb_uart_tx_responder;

  localparam int unsigned N     = 4;
  localparam int unsigned D     = 4;
  localparam logic [31:0] BASE  = 32'h4000_0018;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'd4;
  localparam logic [31:0] A_CTRL = BASE + 32'd8;
  localparam int FRAME   = 10 * N;
  localparam int PITCH   = 10 * N + 1;
  localparam int TIMEOUT = 400;

  logic        clk = 1'b0;
  logic        reset, rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        TX, irqout;

  int cyc = 0;
  int n_checks = 0;
  int n_errs = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] ofs;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[17];

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errs);
    $fatal(1, "watchdog");
  end

  uart_tx_responder #(
    .CLKS_PER_BIT (N),
    .FIFO_DEPTH   (D),
    .BASE         (BASE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .TX     (TX),
    .irqout (irqout)
  );

  // Checking
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver tasks: every bus action occupies one cycle, set up at a negedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; rd = 1'b0; addr = a; wdata = d;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; addr = a;
    #1 d = rdata;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
  endtask

  // Receiver model: finds the start bit, samples every cycle of the frame,
  // decodes mid-bit and checks that each bit is held for exactly N cycles.
  task automatic capture_frame(output logic [7:0] b, output int t0, output bit got);
    logic [FRAME-1:0] samp;
    logic lvl;
    int waited;
    int bad;
    waited = 0; bad = 0; b = '0; t0 = 0; samp = '0;
    @(negedge clk);
    while (TX !== 1'b0 && waited < TIMEOUT) begin
      @(negedge clk);
      waited++;
    end
    got = (TX === 1'b0);
    check("frame_start", 32'(TX), 32'd0);
    if (got) begin
      t0 = cyc;
      for (int k = 0; k < FRAME; k++) begin
        if (k > 0) @(negedge clk);
        samp[k] = TX;
      end
      for (int i = 0; i < 8; i++) b[i] = samp[N + i * N + N / 2];
      for (int k = 0; k < FRAME; k++) begin
        if (k < N)          lvl = 1'b0;
        else if (k < 9 * N) lvl = b[(k - N) / N];
        else                lvl = 1'b1;
        if (samp[k] !== lvl) bad++;
      end
      check("frame_shape", 32'(bad), 32'd0);
    end
  endtask

  // Scoreboard: each decoded byte must match the oldest expected byte.
  task automatic expect_frame(output int t0);
    logic [7:0] b;
    bit got;
    capture_frame(b, t0, got);
    if (got) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL frame_unexpected: got byte 0x%0h, expected no frame", b);
      end else begin
        check("frame_byte", 32'(b), 32'(exp_q.pop_front()));
      end
    end
  endtask

  logic [31:0] r, r1, r2, wd;
  logic [7:0]  rb;
  int tw, t0, k, acc, q, bad;
  int ts[8];
  int ts_r[8];

  initial begin
    // Register-access vectors: {wr, rd, offset, wdata, expected rdata}
    vecs[0]  = '{1'b0, 1'b1, 32'd4,  32'd0,          32'h04};
    vecs[1]  = '{1'b0, 1'b1, 32'd8,  32'd0,          32'h00};
    vecs[2]  = '{1'b1, 1'b0, 32'd8,  32'hFFFF_FFFE,  32'h00};
    vecs[3]  = '{1'b0, 1'b1, 32'd8,  32'd0,          32'h00};
    vecs[4]  = '{1'b1, 1'b0, 32'd8,  32'd3,          32'h00};
    vecs[5]  = '{1'b0, 1'b1, 32'd8,  32'd0,          32'h01};
    vecs[6]  = '{1'b1, 1'b0, 32'd9,  32'd0,          32'h00};
    vecs[7]  = '{1'b0, 1'b1, 32'd8,  32'd0,          32'h01};
    vecs[8]  = '{1'b0, 1'b1, 32'd12, 32'd0,          32'h00};
    vecs[9]  = '{1'b0, 1'b1, 32'd1,  32'd0,          32'h00};
    vecs[10] = '{1'b0, 1'b1, 32'd0,  32'd0,          32'h00};
    vecs[11] = '{1'b0, 1'b0, 32'd4,  32'd0,          32'h00};
    vecs[12] = '{1'b1, 1'b0, 32'd12, 32'h41,         32'h00};
    vecs[13] = '{1'b1, 1'b0, 32'd1,  32'h42,         32'h00};
    vecs[14] = '{1'b0, 1'b1, 32'd4,  32'd0,          32'h04};
    vecs[15] = '{1'b1, 1'b0, 32'd8,  32'd0,          32'h00};
    vecs[16] = '{1'b0, 1'b1, 32'd8,  32'd0,          32'h00};

    reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(TX), 32'd1);
    check("reset_irq", 32'(irqout), 32'd0);
    reset = 1'b0;
    rd = 1'b1; addr = A_ST;
    #1 check("reset_status", rdata, 32'h04);
    addr = A_CTRL;
    #1 check("reset_ctrl", rdata, 32'h00);
    rd = 1'b0;

    // Table-driven register decode
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      wr = vecs[i].wr; rd = vecs[i].rd;
      addr = BASE + vecs[i].ofs; wdata = vecs[i].wdata;
      #1 check($sformatf("vec%0d", i), rdata, vecs[i].exp);
    end
    bus_idle();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (TX !== 1'b1) bad++;
    end
    check("bad_addr_no_frame", 32'(bad), 32'd0);

    // Single byte 0x55: latency, bit order, bit length, tx_done
    fork
      begin
        bus_write(A_TX, 32'hFFFF_FF55);
        tw = cyc;
        exp_q.push_back(8'h55);
        bus_idle();
      end
      begin
        expect_frame(t0);
      end
    join
    check("latency", 32'(t0 - tw), 32'd2);
    bus_read(A_ST, r);
    check("done_status", r, 32'h14);
    bus_read(A_ST, r);
    check("done_cleared", r, 32'h04);
    bus_idle();

    // Five back-to-back writes: in order, 41-cycle pitch, no overflow
    fork
      begin
        for (int i = 1; i <= 5; i++) begin
          bus_write(A_TX, 32'(i));
          exp_q.push_back(8'(i));
        end
        bus_idle();
      end
      begin
        for (int j = 0; j < 5; j++) expect_frame(ts[j]);
      end
    join
    for (int j = 1; j < 5; j++) check($sformatf("pitch5_%0d", j), 32'(ts[j] - ts[j-1]), 32'(PITCH));
    bus_read(A_ST, r);
    check("five_no_overflow", r, 32'h14);
    bus_idle();

    // Six writes: sixth dropped, overflow sticky until read
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          bus_write(A_TX, 32'hA0 + 32'(i));
          if (i < 5) exp_q.push_back(8'hA0 + 8'(i));
        end
        bus_read(A_ST, r1);
        bus_read(A_ST, r2);
        bus_idle();
      end
      begin
        for (int j = 0; j < 5; j++) expect_frame(ts[j]);
      end
    join
    check("six_status", r1, 32'h0B);
    check("six_status_cleared", r2, 32'h03);
    bus_read(A_ST, r);
    check("six_done", r, 32'h14);
    bus_idle();

    // Interrupt enable / masking
    bus_write(A_CTRL, 32'd1);
    bus_read(A_CTRL, r);
    check("ctrl_irq_en", r, 32'd1);
    fork
      begin bus_write(A_TX, 32'h3C); exp_q.push_back(8'h3C); bus_idle(); end
      begin expect_frame(t0); end
    join
    check("irq_before_done", 32'(irqout), 32'd0);
    @(negedge clk);
    check("irq_rise", 32'(irqout), 32'd1);
    bus_read(A_ST, r);
    check("irq_status", r, 32'h14);
    bus_idle();
    check("irq_cleared", 32'(irqout), 32'd0);
    bus_write(A_CTRL, 32'd0);
    fork
      begin bus_write(A_TX, 32'hC3); exp_q.push_back(8'hC3); bus_idle(); end
      begin expect_frame(t0); end
    join
    @(negedge clk);
    check("irq_masked", 32'(irqout), 32'd0);
    bus_read(A_ST, r);
    check("masked_done_status", r, 32'h14);
    bus_idle();

    // Random bursts into an idle, empty transmitter. The first pop happens
    // on the second edge, so D+1 writes fit and the rest are dropped.
    for (int it = 0; it < 10; it++) begin
      k   = int'($urandom_range(1, 7));
      acc = (k < D + 1) ? k : D + 1;
      q   = acc - 1;
      fork
        begin
          for (int i = 0; i < k; i++) begin
            rb = 8'($urandom);
            wd = $urandom;
            wd[7:0] = rb;
            bus_write(A_TX, wd);
            if (i < D + 1) exp_q.push_back(rb);
          end
          bus_idle();
          bus_read(A_ST, r);
          bus_idle();
          check($sformatf("burst%0d_status", it), r,
                (32'(k > D + 1) << 3) | (32'(q == 0) << 2) | (32'(q == D) << 1) | 32'd1);
        end
        begin
          for (int j = 0; j < acc; j++) begin
            expect_frame(ts_r[j]);
            if (j > 0) check($sformatf("burst%0d_pitch", it), 32'(ts_r[j] - ts_r[j-1]), 32'(PITCH));
          end
        end
      join
      bus_read(A_ST, r);
      check($sformatf("burst%0d_done", it), r, 32'h14);
      bus_idle();
      repeat ($urandom_range(0, 4)) bus_idle();
    end

    // Reset in the middle of DATA with bytes still queued
    bus_write(A_TX, 32'h96);
    bus_write(A_TX, 32'h11);
    bus_write(A_TX, 32'h22);
    repeat (8) bus_idle();
    @(negedge clk);
    reset = 1'b1; wr = 1'b1; addr = A_CTRL; wdata = 32'd1;
    @(negedge clk);
    check("abort_tx", 32'(TX), 32'd1);
    reset = 1'b0; wr = 1'b0; rd = 1'b1; addr = A_ST;
    #1 check("abort_status", rdata, 32'h04);
    addr = A_CTRL;
    #1 check("abort_ctrl_write_ignored", rdata, 32'h00);
    rd = 1'b0; addr = '0;
    bad = 0;
    repeat (3 * PITCH) begin
      @(negedge clk);
      if (TX !== 1'b1) bad++;
    end
    check("no_frame_after_reset", 32'(bad), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
